// File: rtl/serial_shift_out.sv
// Parallel-to-serial transmitter: captures D on START and emits it one bit per clock on SO/SV.
// Optional `PARITY_EN appends the even parity bit of the captured word as an extra SV cycle.
module serial_shift_out #(
  parameter int WIDTH = 4
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  input  logic             DIR,
  output logic             SO,
  output logic             SV,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef PARITY_EN
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
`else
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_sr, w_sr_next;
  logic             r_dir, w_dir_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic             r_so, w_so_next;
  logic             r_sv, w_sv_next;
  logic             r_busy, w_busy_next;
  logic             r_done, w_done_next;
`ifdef PARITY_EN
  logic             r_par, w_par_next;
`endif

  always_ff @(posedge C) begin
    if (R) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_dir   <= 1'b0;
      r_cnt   <= '0;
      r_so    <= 1'b0;
      r_sv    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_sr    <= w_sr_next;
      r_dir   <= w_dir_next;
      r_cnt   <= w_cnt_next;
      r_so    <= w_so_next;
      r_sv    <= w_sv_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
`ifdef PARITY_EN
      r_par   <= w_par_next;
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sr_next    = r_sr;
    w_dir_next   = r_dir;
    w_cnt_next   = r_cnt;
    w_so_next    = 1'b0;
    w_sv_next    = 1'b0;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
`ifdef PARITY_EN
    w_par_next   = r_par;
`endif
    case (r_state)
      IDLE: begin
        w_busy_next = 1'b0;
        if (START) begin
          w_sr_next    = D;
          w_dir_next   = DIR;
          w_so_next    = DIR ? D[0] : D[WIDTH-1];
          w_sv_next    = 1'b1;
          w_busy_next  = 1'b1;
          w_cnt_next   = CNT_LOAD;
          w_state_next = SHIFT;
`ifdef PARITY_EN
          w_par_next   = ^D;
`endif
        end
      end
      SHIFT: begin
        if (r_cnt != '0) begin
          // Next bit is the one adjacent to the exit end before this shift.
          w_sr_next   = r_dir ? (r_sr >> 1) : (r_sr << 1);
          w_so_next   = r_dir ? r_sr[1] : r_sr[WIDTH-2];
`ifdef PARITY_EN
          if (r_cnt == CW'(1)) w_so_next = r_par;
`endif
          w_sv_next   = 1'b1;
          w_busy_next = 1'b1;
          w_cnt_next  = r_cnt - CW'(1);
        end else begin
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign SO   = r_so;
  assign SV   = r_sv;
  assign BUSY = r_busy;
  assign DONE = r_done;

endmodule

// File: tb/tb_serial_shift_out.sv
// Bench for serial_shift_out: frame-level queue model checked every cycle, plus directed literal cases.
module tb_serial_shift_out;

  localparam int W = 4;
`ifdef PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         C = 1'b0;
  logic         R = 1'b1;
  logic [W-1:0] D = '0;
  logic         START = 1'b0;
  logic         DIR = 1'b0;
  logic         SO, SV, BUSY, DONE;

  int n_checks = 0;
  int n_fail = 0;

  serial_shift_out #(.WIDTH(W)) dut (
    .C(C), .R(R), .D(D), .START(START), .DIR(DIR),
    .SO(SO), .SV(SV), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 C = ~C;

  typedef struct packed {
    logic so;
    logic sv;
    logic busy;
    logic done;
  } out_t;

  out_t         q[$];
  out_t         exp_o = '0;
  out_t         ent;
  logic [W-1:0] f_word = '0;
  logic         f_dir = 1'b0;
  logic         chk_en = 1'b0;

  // Frame model: on acceptance, the whole expected output sequence of the frame is queued.
  always @(posedge C) begin
    if (R) begin
      q.delete();
      exp_o = '0;
    end else if (q.size() == 0) begin
      if (START) begin
        f_word = D;
        f_dir  = DIR;
        for (int k = 0; k < W; k++) begin
          ent.so = DIR ? D[k] : D[W-1-k];
          ent.sv = 1'b1; ent.busy = 1'b1; ent.done = 1'b0;
          q.push_back(ent);
        end
`ifdef PARITY_EN
        ent.so = ^D; ent.sv = 1'b1; ent.busy = 1'b1; ent.done = 1'b0;
        q.push_back(ent);
`endif
        ent = '0; ent.done = 1'b1;
        q.push_back(ent);
        exp_o = q.pop_front();
      end else begin
        exp_o = '0;
      end
    end else begin
      exp_o = q.pop_front();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Receiver fed by SO/SV; at DONE it must hold the frame's original word.
  logic [W-1:0] rx = '0;
  int           rx_n = 0;
  logic [W-1:0] last_rx = '0;
  int           n_frames = 0;

  always @(negedge C) begin
    if (chk_en) begin
      n_checks++;
      if ({SO, SV, BUSY, DONE} !== exp_o) begin
        n_fail++;
        $display("FAIL outputs: got so/sv/busy/done=%b%b%b%b, expected %b%b%b%b at %0t",
                 SO, SV, BUSY, DONE, exp_o.so, exp_o.sv, exp_o.busy, exp_o.done, $time);
      end
      if (SV && rx_n < W) begin
        rx = f_dir ? {SO, rx[W-1:1]} : {rx[W-2:0], SO};
        rx_n++;
      end
      if (DONE) begin
        n_checks++;
        n_frames++;
        if (rx !== f_word || rx_n != W) begin
          n_fail++;
          $display("FAIL receiver: got %b (%0d bits), expected %b", rx, rx_n, f_word);
        end
        last_rx = rx;
        rx_n = 0;
      end else if (!BUSY) begin
        rx_n = 0;
      end
    end
  end

  task automatic capture(input logic [W-1:0] d, input logic dir,
                         output logic [31:0] bits, output int sv_cnt, output int done_at);
    bits = '0; sv_cnt = 0; done_at = -1;
    @(negedge C); START = 1'b1; D = d; DIR = dir;
    for (int c = 1; c <= NB + 2; c++) begin
      @(negedge C); START = 1'b0;
      if (SV) begin bits = {bits[30:0], SO}; sv_cnt++; end
      if (DONE && done_at < 0) done_at = c;
    end
  endtask

  logic [31:0] bits;
  int          sv_cnt, done_at, first_sv, last_sv, done_seen;

  initial begin
    // Test 1: reset with START high
    R = 1'b1; START = 1'b1; D = 4'b1011;
    @(posedge C); #1 chk_en = 1'b1;
    @(posedge C); #1;
    check("reset_outputs", {28'd0, SO, SV, BUSY, DONE}, 32'd0);
    @(negedge C); R = 1'b0; START = 1'b0;
    @(negedge C);

    // Test 2: MSB first
    capture(4'b1011, 1'b0, bits, sv_cnt, done_at);
`ifdef PARITY_EN
    check("msb_bits_parity", bits, 32'b10111);
`else
    check("msb_bits", bits, 32'b1011);
`endif
    check("msb_sv_count", sv_cnt, NB);
    check("msb_done_cycle", done_at, NB + 1);
    check("msb_receiver", {28'd0, last_rx}, 32'b1011);

    // Test 3: LSB first, SHR receiver
    capture(4'b1011, 1'b1, bits, sv_cnt, done_at);
`ifdef PARITY_EN
    check("lsb_bits_parity", bits, 32'b11011);
`else
    check("lsb_bits", bits, 32'b1101);
`endif
    check("lsb_done_cycle", done_at, NB + 1);
    check("lsb_receiver", {28'd0, last_rx}, 32'b1011);

    // Test 4: START held, D changed mid-frame
    @(negedge C); START = 1'b1; D = 4'b1011; DIR = 1'b0;
    bits = '0; first_sv = -1; last_sv = -1;
    for (int c = 1; c <= 2 * NB + 2; c++) begin
      @(negedge C);
      D = 4'b0110;
      if (SV) begin
        bits = {bits[30:0], SO};
        if (first_sv < 0) first_sv = c;
        last_sv = c;
      end
    end
    START = 1'b0;
`ifdef PARITY_EN
    check("b2b_bits_parity", bits, 32'b10111_01100);
`else
    check("b2b_bits", bits, 32'b1011_0110);
`endif
    check("b2b_span", last_sv - first_sv + 1, 2 * NB + 1);
    @(negedge C); @(negedge C);

    // Test 5: reset on the third data cycle
    @(negedge C); START = 1'b1; D = 4'b1011; DIR = 1'b0;
    @(negedge C); START = 1'b0;
    @(negedge C);
    @(negedge C); R = 1'b1;
    @(negedge C); R = 1'b0;
    check("abort_outputs", {28'd0, SO, SV, BUSY, DONE}, 32'd0);
    done_seen = 0;
    for (int c = 0; c < NB + 2; c++) begin
      @(negedge C);
      if (DONE) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    capture(4'b1011, 1'b0, bits, sv_cnt, done_at);
`ifdef PARITY_EN
    check("after_abort_bits", bits, 32'b10111);
`else
    check("after_abort_bits", bits, 32'b1011);
`endif
    check("after_abort_done", done_at, NB + 1);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge C);
      START = ($urandom_range(0, 1) == 1);
      D     = W'($urandom);
      DIR   = $urandom_range(0, 1) == 1;
      R     = ($urandom_range(0, 79) == 0);
    end
    @(negedge C); R = 1'b0; START = 1'b0;
    for (int c = 0; c < NB + 3; c++) @(negedge C);
    n_checks++;
    if (n_frames < 50) begin
      n_fail++;
      $display("FAIL frame_count: got %0d, expected at least 50", n_frames);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
